// File: rtl/log_arbiter.sv
// Round-robin front end that shares one signed LOG core between NREQ requesters.
// One operation in flight; non-positive operands are answered locally with an error.
module log_arbiter #(
  parameter int M    = 4,
  parameter int N    = 10,
  parameter int NREQ = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*(M+N+1)-1:0] req_data,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [M+N:0]          resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic [M+N:0]          log_number,
  output logic                  log_iValid,
  input  logic                  log_iReady,
  input  logic [M+N:0]          log_logNumber,
  input  logic                  log_oValid,
  output logic                  log_oReady
);

  localparam int W  = M + N + 1;
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t          state_r;
  logic [GW-1:0]   last_grant_r;
  logic [GW-1:0]   gnt_r;
  logic [GW-1:0]   grant_s;
  logic            found_s;
  logic [W-1:0]    sel_data_s;
  logic            positive_s;
  logic [W-1:0]    data_arr_s [NREQ];

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] idx);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr_s[gi] = req_data[gi*W +: W];
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic [GW-1:0] cand;
    logic          hit;
    grant_s = last_grant_r;
    found_s = 1'b0;
    cand    = {GW{1'b0}};
    hit     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand    = GW'((int'(last_grant_r) + k) % NREQ);
      hit     = req_valid[cand] && !found_s;
      grant_s = hit ? cand : grant_s;
      found_s = found_s | hit;
    end
    sel_data_s = data_arr_s[grant_s];
    positive_s = !sel_data_s[W-1] && (sel_data_s != {W{1'b0}});
  end

  // Arbitration / LOG handshake FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= S_IDLE;
      last_grant_r <= GW'(NREQ - 1);
      gnt_r        <= {GW{1'b0}};
      req_ready    <= {NREQ{1'b0}};
      resp_valid   <= {NREQ{1'b0}};
      resp_data    <= {W{1'b0}};
      resp_err     <= 1'b0;
      busy         <= 1'b0;
      log_number   <= {W{1'b0}};
      log_iValid   <= 1'b0;
      log_oReady   <= 1'b0;
    end else begin
      req_ready <= {NREQ{1'b0}};
      case (state_r)
        S_IDLE: begin
          if (found_s) begin
            req_ready  <= onehot(grant_s);
            gnt_r      <= grant_s;
            log_number <= sel_data_s;
            busy       <= 1'b1;
            if (positive_s) begin
              log_iValid <= 1'b1;
              state_r    <= S_ISSUE;
            end else begin
              resp_data  <= {W{1'b0}};
              resp_err   <= 1'b1;
              resp_valid <= onehot(grant_s);
              state_r    <= S_RETURN;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (log_iValid && log_iReady) begin
            log_iValid <= 1'b0;
            log_oReady <= 1'b1;
            state_r    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (log_oValid && log_oReady) begin
            log_oReady <= 1'b0;
            resp_data  <= log_logNumber;
            resp_err   <= 1'b0;
            resp_valid <= onehot(gnt_r);
            state_r    <= S_RETURN;
          end
        end
        S_RETURN: begin
          // Only the granted requester's ready completes the response.
          if (resp_ready[gnt_r]) begin
            resp_valid   <= {NREQ{1'b0}};
            last_grant_r <= gnt_r;
            busy         <= 1'b0;
            state_r      <= S_IDLE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          resp_valid <= {NREQ{1'b0}};
          log_iValid <= 1'b0;
          log_oReady <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/log_arbiter.md
Name: log_arbiter

Overview:
- Shares one LOG unit (Q(M+1).N signed logarithm core, iValid/iReady in, oValid/oReady out) between NREQ independent requesters.
- Round-robin arbitration with one operation in flight at a time. Drives LOG's number/iValid/oReady and captures logNumber. Routes each result back to the requester that issued it.
- Non-positive operands are rejected locally without occupying LOG.
- Sits between client datapaths and the single LOG instance, in the same clock domain.

Parameters:
- M, 4, integer bits of operand/result (excluding sign)
- N, 10, fractional bits; data width W = M+N+1
- NREQ, 4, number of requesters (2..8)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept pulse
- req_data  in  NREQ*W  operands, requester i at bits [i*W +: W], signed fixed point
- resp_valid  out  NREQ  per-requester result valid (one-hot or zero)
- resp_ready  in  NREQ  per-requester result accept
- resp_data  out  W  result, shared by all requesters, qualified by resp_valid
- resp_err  out  1  result invalid: operand was <= 0
- busy  out  1  high in any state except IDLE
- log_number  out  W  to LOG number
- log_iValid  out  1  to LOG iValid
- log_iReady  in  1  from LOG iReady
- log_logNumber  in  W  from LOG logNumber
- log_oValid  in  1  from LOG oValid
- log_oReady  out  1  to LOG oReady

Behaviour:
- Reset values:
  - All outputs 0. State IDLE.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - Operand and result registers 0.
- All outputs are registered. The FSM states are IDLE, ISSUE, WAIT, RETURN.
- IDLE:
  - If any req_valid is high, grant g = first index with req_valid high, searching from last_grant+1 upward and wrapping modulo NREQ.
  - Latch req_data[g] and g. Assert req_ready[g] for exactly one cycle.
  - Operand > 0: go to ISSUE.
  - Operand <= 0 (sign bit set, or all zero): load result = 0, set err = 1, go directly to RETURN.
- ISSUE:
  - log_iValid = 1 and log_number = latched operand, held stable.
  - On a cycle where log_iValid and log_iReady are both high: transfer occurs. Next cycle log_iValid = 0, log_oReady = 1, go to WAIT.
- WAIT:
  - log_oReady = 1.
  - On a cycle where log_oValid and log_oReady are both high: capture log_logNumber bit-exact and set err = 0. Next cycle log_oReady = 0, go to RETURN.
- RETURN:
  - resp_valid[g] = 1, resp_data = result, resp_err = err. All three held stable until resp_ready[g] is high.
  - On that handshake: go to IDLE, last_grant = g, resp_valid cleared next cycle.
  - resp_ready on other indices is ignored.
- Minimum latency:
  - Accept at cycle t, log_iValid at t+1. If log_iReady is already high, log_oReady at t+2.
  - resp_valid appears 1 cycle after the log_oValid handshake.
  - Reject path: resp_valid at t+1.
- New grants are made only in IDLE, so at most one requester is in flight. Requests arriving in any other state wait; there is no queueing inside the block.
- A requester must hold req_valid and req_data until its req_ready pulse. The block does not check this.
- Fairness: a requester that was just served has lowest priority in the next arbitration. Each continuously requesting requester is served within NREQ grants.
- Reset mid-operation:
  - Immediately returns to IDLE and drops log_iValid, log_oReady and resp_valid.
  - A pending LOG result is abandoned. LOG shares the same reset.
  - A log_oValid seen while not in WAIT is ignored, because log_oReady is 0.
- No arithmetic beyond the sign/zero test. Widths pass through unchanged.

Test Plan:
- Operand path: Bench LOG stub with 3-cycle latency, returning 15'h0494 for any input. Requester 2 sends 15'b00011_0010010000.
  - Required: req_ready[2] for 1 cycle.
  - Required: log_number equals the operand during log_iValid.
  - Required: resp_valid[2] with resp_data = 15'h0494 and resp_err = 0.
- Round-robin order: All four requesters hold valid positive operands continuously. Required grant order is 0,1,2,3,0,1. No requester is granted twice before all others are served.
- Reject path: Requester 1 sends 15'h7C00 (negative), then 15'h0000.
  - Required: each yields resp_valid[1] at accept+1, resp_data = 0, resp_err = 1.
  - Required: log_iValid never rises.
- Backpressure: resp_ready[0] held low for 10 cycles.
  - Required: resp_valid[0], resp_data and resp_err stay stable.
  - Required: no new req_ready pulse while resp_ready[0] is low. The next grant occurs only after resp_ready[0] goes high.
- LOG stall: log_iReady held low for 5 cycles. Required: log_iValid and log_number stay stable, and the transfer happens on the first cycle log_iReady is high.
- Reset mid-operation: reset asserted in WAIT.
  - Required: all outputs 0 on the next cycle and state IDLE.
  - Required: a subsequent stale log_oValid produces no resp_valid.
  - Required: the first post-reset grant goes to requester 0.
